// File: rtl/addrc_multi_cu.sv
`default_nettype none
// addrc_multi_cu: multi-word load sequencer (IDLE/LOAD/GAP_W/DONE) with stall, inter-word gap and abort.
// Revision 1.0
module addrc_multi_cu #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] count,
  input  logic             stall,
  input  logic             abort,
  output logic             ready,
  output logic             ld,
  output logic [IDX_W-1:0] ld_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAPW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [GW-1:0]    C_GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [IDX_W-1:0] C_LAST_MAX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W:0]   C_NUM_EXT  = (IDX_W + 1)'(NUM_WORDS);

  logic [1:0]       ps_q, ps_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0] last_w;

  // The last index is stored rather than the count so NUM_WORDS = 2**IDX_W still fits.
  assign last_w = ((count == '0) || ({1'b0, count} > C_NUM_EXT)) ? C_LAST_MAX
                                                                : count - IDX_W'(1);

  always_comb begin
    ps_d   = ps_q;
    idx_d  = idx_q;
    last_d = last_q;
    gap_d  = gap_q;
    case (ps_q)
      S_IDLE: begin
        if (start) begin
          last_d = last_w;
          idx_d  = '0;
          gap_d  = '0;
          ps_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          ps_d  = S_IDLE;
          idx_d = '0;
        end else if (!stall) begin
          if (idx_q == last_q) begin
            ps_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            gap_d = '0;
            ps_d  = (GAP == 0) ? S_LOAD : S_GAPW;
          end
        end
      end
      S_GAPW: begin
        if (abort) begin
          ps_d  = S_IDLE;
          idx_d = '0;
          gap_d = '0;
        end else if (gap_q == C_GAP_LAST) begin
          gap_d = '0;
          ps_d  = S_LOAD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        ps_d = S_IDLE;
      end
      default: begin
        ps_d  = S_IDLE;
        idx_d = '0;
        gap_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q   <= S_IDLE;
      idx_q  <= '0;
      last_q <= '0;
      gap_q  <= '0;
    end else begin
      ps_q   <= ps_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      gap_q  <= gap_d;
    end
  end

  assign ready  = (ps_q == S_IDLE);
  assign busy   = (ps_q == S_LOAD) || (ps_q == S_GAPW);
  assign ld     = (ps_q == S_LOAD) && !stall && !abort;
  assign ld_idx = idx_q;
  assign done   = (ps_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_addrc_multi_cu.sv
`default_nettype none
// tb_addrc_multi_cu: scoreboard bench for addrc_multi_cu (GAP=0 and GAP=2 instances).
// Revision 1.0
module tb_addrc_multi_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic       a_start = 1'b0, a_stall = 1'b0, a_abort = 1'b0;
  logic [2:0] a_count = '0;
  logic       a_ready, a_ld, a_busy, a_done;
  logic [2:0] a_idx;

  logic       b_start = 1'b0, b_stall = 1'b0, b_abort = 1'b0;
  logic [1:0] b_count = '0;
  logic       b_ready, b_ld, b_busy, b_done;
  logic [1:0] b_idx;

  addrc_multi_cu #(.NUM_WORDS(4), .IDX_W(3), .GAP(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .count(a_count), .stall(a_stall), .abort(a_abort),
    .ready(a_ready), .ld(a_ld), .ld_idx(a_idx), .busy(a_busy), .done(a_done)
  );

  addrc_multi_cu #(.NUM_WORDS(4), .IDX_W(2), .GAP(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .count(b_count), .stall(b_stall), .abort(b_abort),
    .ready(b_ready), .ld(b_ld), .ld_idx(b_idx), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int is_done;
    int idx;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  function automatic void push_a(int s, int d, int i);
    ev_t e;
    e.stamp = s; e.is_done = d; e.idx = i;
    qa.push_back(e);
  endfunction

  function automatic void push_b(int s, int d, int i);
    ev_t e;
    e.stamp = s; e.is_done = d; e.idx = i;
    qb.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitors: every ld or done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (a_ld || a_done) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL A_event cyc=%0d actual ld=%0b done=%0b idx=%0d required no event",
                 cyc, a_ld, a_done, a_idx);
      end else begin
        ev_t e;
        e = qa.pop_front();
        if (e.stamp != cyc || e.is_done != int'(a_done) || e.is_done == int'(a_ld) ||
            (e.is_done == 0 && e.idx != int'(a_idx))) begin
          n_err++;
          $display("FAIL A_event actual cyc=%0d ld=%0b done=%0b idx=%0d required cyc=%0d done=%0d idx=%0d",
                   cyc, a_ld, a_done, a_idx, e.stamp, e.is_done, e.idx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_ld || b_done) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL B_event cyc=%0d actual ld=%0b done=%0b idx=%0d required no event",
                 cyc, b_ld, b_done, b_idx);
      end else begin
        ev_t e;
        e = qb.pop_front();
        if (e.stamp != cyc || e.is_done != int'(b_done) || e.is_done == int'(b_ld) ||
            (e.is_done == 0 && e.idx != int'(b_idx))) begin
          n_err++;
          $display("FAIL B_event actual cyc=%0d ld=%0b done=%0b idx=%0d required cyc=%0d done=%0d idx=%0d",
                   cyc, b_ld, b_done, b_idx, e.stamp, e.is_done, e.idx);
        end
      end
    end
  end

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_a(input logic [2:0] c, output int b);
    chk("A_ready_before_start", int'(a_ready), 1);
    a_start = 1'b1;
    a_count = c;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b = cyc;
  endtask

  task automatic go_b(input logic [1:0] c, output int b);
    chk("B_ready_before_start", int'(b_ready), 1);
    b_start = 1'b1;
    b_count = c;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_ready", int'(a_ready), 1);
    chk("rst_ld",    int'(a_ld),    0);
    chk("rst_idx",   int'(a_idx),   0);
    chk("rst_busy",  int'(a_busy),  0);
    chk("rst_done",  int'(a_done),  0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // count=3, back-to-back
    go_a(3'd3, base);
    push_a(base, 0, 0); push_a(base + 1, 0, 1); push_a(base + 2, 0, 2); push_a(base + 3, 1, 0);
    @(negedge clk);
    chk("c3_busy_cycle1", int'(a_busy), 1);
    tick_to(base + 3);
    @(negedge clk);
    chk("c3_ready_cycle4", int'(a_ready), 0);
    chk("c3_busy_cycle4",  int'(a_busy),  0);
    tick_to(base + 4);
    @(negedge clk);
    chk("c3_ready_cycle5", int'(a_ready), 1);
    chk("c3_idx_held",     int'(a_idx),   2);
    tick_to(base + 5);

    // count=0 and count=7 both clamp to NUM_WORDS
    go_a(3'd0, base);
    push_a(base, 0, 0); push_a(base + 1, 0, 1); push_a(base + 2, 0, 2); push_a(base + 3, 0, 3);
    push_a(base + 4, 1, 0);
    tick_to(base + 5);
    go_a(3'd7, base);
    push_a(base, 0, 0); push_a(base + 1, 0, 1); push_a(base + 2, 0, 2); push_a(base + 3, 0, 3);
    push_a(base + 4, 1, 0);
    tick_to(base + 5);

    // stall two cycles at idx 1
    go_a(3'd4, base);
    push_a(base, 0, 0); push_a(base + 3, 0, 1); push_a(base + 4, 0, 2); push_a(base + 5, 0, 3);
    push_a(base + 6, 1, 0);
    tick_to(base + 1);
    a_stall = 1'b1;
    @(negedge clk);
    chk("stall_ld",   int'(a_ld),   0);
    chk("stall_idx1", int'(a_idx),  1);
    tick_to(base + 2);
    @(negedge clk);
    chk("stall_idx2", int'(a_idx),  1);
    chk("stall_busy", int'(a_busy), 1);
    tick_to(base + 3);
    a_stall = 1'b0;
    tick_to(base + 7);

    // abort (with stall) at idx 2; start while busy ignored
    go_a(3'd4, base);
    push_a(base, 0, 0); push_a(base + 1, 0, 1);
    tick_to(base + 1);
    a_start = 1'b1;
    a_count = 3'd1;
    tick_to(base + 2);
    a_start = 1'b0;
    a_abort = 1'b1;
    a_stall = 1'b1;
    @(negedge clk);
    chk("abort_ld",   int'(a_ld),   0);
    chk("abort_idx",  int'(a_idx),  2);
    tick_to(base + 3);
    a_abort = 1'b0;
    a_stall = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(a_ready), 1);
    chk("abort_idx0",  int'(a_idx),   0);
    tick_to(base + 4);
    go_a(3'd2, base);
    push_a(base, 0, 0); push_a(base + 1, 0, 1); push_a(base + 2, 1, 0);
    tick_to(base + 3);

    // GAP=2 instance, count=2
    go_b(2'd2, base);
    push_b(base, 0, 0); push_b(base + 3, 0, 1); push_b(base + 4, 1, 0);
    tick_to(base + 1);
    @(negedge clk);
    chk("gap_busy", int'(b_busy), 1);
    chk("gap_ld",   int'(b_ld),   0);
    tick_to(base + 5);
    @(negedge clk);
    chk("gap_ready", int'(b_ready), 1);
    tick_to(base + 6);

    // GAP=2 instance, abort inside the gap
    go_b(2'd0, base);
    push_b(base, 0, 0); push_b(base + 3, 0, 1);
    tick_to(base + 4);
    b_abort = 1'b1;
    tick_to(base + 5);
    b_abort = 1'b0;
    @(negedge clk);
    chk("gap_abort_ready", int'(b_ready), 1);
    chk("gap_abort_idx",   int'(b_idx),   0);
    tick_to(base + 6);

    // asynchronous reset mid-transaction
    go_a(3'd4, base);
    push_a(base, 0, 0);
    tick_to(base + 1);
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(a_ready), 1);
    chk("midrst_ld",    int'(a_ld),    0);
    chk("midrst_idx",   int'(a_idx),   0);
    chk("midrst_busy",  int'(a_busy),  0);
    chk("midrst_done",  int'(a_done),  0);
    @(negedge clk);
    rst = 1'b1;
    tick_to(cyc + 1);
    go_a(3'd1, base);
    push_a(base, 0, 0); push_a(base + 1, 1, 0);
    tick_to(base + 3);

    chk("A_queue_drained", qa.size(), 0);
    chk("B_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
